wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 106 ++++++++++
 tb/tb_wb_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback-stage register file: two bypassed combinational read ports, dual commit
// writes (M beats E), sticky halt on bad status and a saturating retired-instruction counter.
module wb_regfile #(
  parameter int unsigned        DATA_W  = 64,
  parameter int unsigned        NREGS   = 16,
  parameter int unsigned        IDX_W   = 4,
  parameter int unsigned        RNONE   = 15,
  parameter int unsigned        SP_IDX  = 4,
  parameter logic [DATA_W-1:0]  SP_INIT = {DATA_W{1'b0}},
  parameter int unsigned        CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              W_icode,
  input  logic [DATA_W-1:0]       W_valE,
  input  logic [DATA_W-1:0]       W_valM,
  input  logic [IDX_W-1:0]        W_dstE,
  input  logic [IDX_W-1:0]        W_dstM,
  input  logic [1:0]              W_stat,
  input  logic                    W_bubble,
  input  logic [IDX_W-1:0]        srcA,
  input  logic [IDX_W-1:0]        srcB,
  output logic [DATA_W-1:0]       valA_rf,
  output logic [DATA_W-1:0]       valB_rf,
  output logic [1:0]              w_stat,
  output logic                    halted,
  output logic [CNT_W-1:0]        retired_cnt,
  output logic [NREGS*DATA_W-1:0] regs_flat
);

  localparam logic [1:0] StatAok = 2'd0;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [1:0]        r_stat;
  logic              r_halted;
  logic [CNT_W-1:0]  r_cnt;

  logic w_valid;
  logic w_fault;
  logic w_we_e;
  logic w_we_m;

  // Destinations arrive pre-resolved, so the icode carries no information here.
  logic w_unused_icode;
  assign w_unused_icode = ^W_icode;

  assign w_valid = !W_bubble && !r_halted && (W_stat == StatAok);
  assign w_fault = !W_bubble && !r_halted && (W_stat != StatAok);
  assign w_we_e  = w_valid && (32'(W_dstE) != RNONE) && (32'(W_dstE) < NREGS);
  assign w_we_m  = w_valid && (32'(W_dstM) != RNONE) && (32'(W_dstM) < NREGS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == SP_IDX) ? SP_INIT : {DATA_W{1'b0}};
      end
      r_stat   <= StatAok;
      r_halted <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
    end else begin
      // M is checked first so it wins a same-index collision (popq %rsp).
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (w_we_m && (W_dstM == IDX_W'(i))) begin
          r_regs[i] <= W_valM;
        end else if (w_we_e && (W_dstE == IDX_W'(i))) begin
          r_regs[i] <= W_valE;
        end
      end
      if (w_valid && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_fault) begin
        r_stat   <= W_stat;
        r_halted <= 1'b1;
      end
    end
  end

  always_comb begin
    valA_rf = {DATA_W{1'b0}};
    valB_rf = {DATA_W{1'b0}};
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (i != RNONE) begin
        if (srcA == IDX_W'(i)) valA_rf = r_regs[i];
        if (srcB == IDX_W'(i)) valB_rf = r_regs[i];
      end
    end
    // Bypass the committing writes; M overrides E.
    if (w_we_e && (srcA == W_dstE)) valA_rf = W_valE;
    if (w_we_m && (srcA == W_dstM)) valA_rf = W_valM;
    if (w_we_e && (srcB == W_dstE)) valB_rf = W_valE;
    if (w_we_m && (srcB == W_dstM)) valB_rf = W_valM;
  end

  always_comb begin
    regs_flat = {NREGS*DATA_W{1'b0}};
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_flat[i*DATA_W +: DATA_W] = r_regs[i];
    end
  end

  assign w_stat      = r_stat;
  assign halted      = r_halted;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboarded bench for wb_regfile: a driver pushes model expectations per cycle,
// a negedge monitor pops and compares them against two DUTs (32-bit and 4-bit counters).
module tb_wb_regfile;

  localparam logic [63:0] SpInit = 64'h0000_0000_0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [1:0]  W_stat;
  logic        W_bubble;
  logic [3:0]  srcA, srcB;

  logic [63:0]   valA_rf, valB_rf, c_valA_rf, c_valB_rf;
  logic [1:0]    w_stat, c_w_stat;
  logic          halted, c_halted;
  logic [31:0]   retired_cnt;
  logic [3:0]    c_retired_cnt;
  logic [1023:0] regs_flat, c_regs_flat;

  wb_regfile #(.SP_INIT(SpInit)) dut (
    .clk(clk), .reset(reset), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_stat(W_stat), .W_bubble(W_bubble),
    .srcA(srcA), .srcB(srcB), .valA_rf(valA_rf), .valB_rf(valB_rf), .w_stat(w_stat),
    .halted(halted), .retired_cnt(retired_cnt), .regs_flat(regs_flat)
  );

  wb_regfile #(.SP_INIT(SpInit), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_stat(W_stat), .W_bubble(W_bubble),
    .srcA(srcA), .srcB(srcB), .valA_rf(c_valA_rf), .valB_rf(c_valB_rf), .w_stat(c_w_stat),
    .halted(c_halted), .retired_cnt(c_retired_cnt), .regs_flat(c_regs_flat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          chk_rd;
    logic [63:0]   a;
    logic [63:0]   b;
    logic [1023:0] regs;
    logic [1:0]    st;
    logic          hl;
    logic [31:0]   cnt;
    logic [3:0]    cnt4;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state.
  logic [63:0] m_regs [16];
  logic [1:0]  m_stat;
  logic        m_halted;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = (i == 4) ? SpInit : 64'd0;
    m_stat   = 2'd0;
    m_halted = 1'b0;
    m_cnt    = 0;
  endfunction

  function automatic logic [63:0] model_read(input logic [3:0] s, input logic v,
                                             input logic [3:0] de, input logic [63:0] ve,
                                             input logic [3:0] dm, input logic [63:0] vm);
    if (s == 4'd15) return 64'd0;
    if (v && dm == s) return vm;
    if (v && de == s) return ve;
    return m_regs[s];
  endfunction

  task automatic cycle(input logic rst, input logic [1:0] st, input logic bub,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    exp_t e;
    logic v;
    @(posedge clk);
    #2;
    reset = rst; W_stat = st; W_bubble = bub; W_dstE = de; W_valE = ve;
    W_dstM = dm; W_valM = vm; srcA = sa; srcB = sb; W_icode = 4'($urandom_range(0, 11));
    v = !bub && !m_halted && (st == 2'd0);
    e.chk_rd = !rst;
    e.a      = model_read(sa, v, de, ve, dm, vm);
    e.b      = model_read(sb, v, de, ve, dm, vm);
    for (int i = 0; i < 16; i++) e.regs[i*64 +: 64] = m_regs[i];
    e.st   = m_stat;
    e.hl   = m_halted;
    e.cnt  = 32'(m_cnt);
    e.cnt4 = (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
    q.push_back(e);
    if (rst) begin
      model_reset();
    end else if (!bub && !m_halted) begin
      if (st == 2'd0) begin
        if (de != 4'd15) m_regs[de] = ve;
        if (dm != 4'd15) m_regs[dm] = vm;
        m_cnt++;
      end else begin
        m_stat   = st;
        m_halted = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk_rd) begin
        chk("valA", valA_rf, e.a);
        chk("valB", valB_rf, e.b);
        chk("valA_c", c_valA_rf, e.a);
      end
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("reg%0d", i), regs_flat[i*64 +: 64], e.regs[i*64 +: 64]);
      end
      chk("c_regs4", c_regs_flat[4*64 +: 64], e.regs[4*64 +: 64]);
      chk("w_stat", 64'(w_stat), 64'(e.st));
      chk("halted", 64'(halted), 64'(e.hl));
      chk("c_halted", 64'(c_halted), 64'(e.hl));
      chk("retired_cnt", 64'(retired_cnt), 64'(e.cnt));
      chk("retired_cnt4", 64'(c_retired_cnt), 64'(e.cnt4));
    end
  end

  initial begin
    logic [1:0] st;
    reset = 1'b1; W_icode = 4'd0; W_valE = '0; W_valM = '0; W_dstE = 4'd15;
    W_dstM = 4'd15; W_stat = 2'd0; W_bubble = 1'b0; srcA = 4'd0; srcB = 4'd0;
    repeat (2) @(posedge clk);
    model_reset();

    // irmovq with same-cycle bypass, popq %rsp, bubble, ADR halt, ignored write, reset mid-halt.
    cycle(0, 2'd0, 0, 4'd2, 64'd5,     4'd15, 64'd0,    4'd2, 4'd15);
    cycle(0, 2'd0, 0, 4'd4, 64'h108,   4'd4,  64'hAA,   4'd4, 4'd2);
    cycle(0, 2'd0, 1, 4'd3, 64'd7,     4'd15, 64'd0,    4'd3, 4'd4);
    cycle(0, 2'd2, 0, 4'd1, 64'd9,     4'd15, 64'd0,    4'd1, 4'd2);
    cycle(0, 2'd0, 0, 4'd5, 64'h55,    4'd15, 64'd0,    4'd5, 4'd1);
    cycle(0, 2'd0, 0, 4'd6, 64'h66,    4'd7,  64'h77,   4'd6, 4'd7);
    cycle(1, 2'd0, 0, 4'd4, 64'd99,    4'd4,  64'd77,   4'd4, 4'd15);
    cycle(0, 2'd0, 1, 4'd15, 64'd0,    4'd15, 64'd0,    4'd4, 4'd15);

    // 17 commits: 4-bit counter must saturate at 15.
    for (int k = 0; k < 17; k++) begin
      cycle(0, 2'd0, 0, 4'(k % 14), 64'(k * 3 + 1), 4'd15, 64'd0, 4'(k % 16), 4'((k + 5) % 16));
    end

    for (int k = 0; k < 600; k++) begin
      st = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cycle(($urandom_range(0, 59) == 0), st, ($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)), {$urandom, $urandom},
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd15,
            {$urandom, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    cycle(0, 2'd0, 1, 4'd15, 64'd0, 4'd15, 64'd0, 4'd0, 4'd15);
    repeat (3) @(posedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
